// File: rtl/iob_cpu_bus_bridge.sv
// Registered bridge from a CPU native memory port to one IOb instruction bus and
// N_SLAVES address-decoded IOb data buses; one outstanding transaction at a time.
module iob_cpu_bus_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 2,
    parameter int SEL_BITS = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,
    input  logic                       cpu_valid_i,
    input  logic                       cpu_instr_i,
    input  logic [ADDR_W-1:0]          cpu_addr_i,
    input  logic [DATA_W-1:0]          cpu_wdata_i,
    input  logic [DATA_W/8-1:0]        cpu_wstrb_i,
    output logic [DATA_W-1:0]          cpu_rdata_o,
    output logic                       cpu_ready_o,
    output logic                       err_o,
    output logic                       ibus_valid_o,
    output logic [ADDR_W-1:0]          ibus_addr_o,
    input  logic                       ibus_ready_i,
    input  logic                       ibus_rvalid_i,
    input  logic [DATA_W-1:0]          ibus_rdata_i,
    output logic [N_SLAVES-1:0]        dbus_valid_o,
    output logic [ADDR_W-1:0]          dbus_addr_o,
    output logic [DATA_W-1:0]          dbus_wdata_o,
    output logic [DATA_W/8-1:0]        dbus_wstrb_o,
    input  logic [N_SLAVES-1:0]        dbus_ready_i,
    input  logic [N_SLAVES-1:0]        dbus_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0] dbus_rdata_i
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;

    state_t              state;
    logic                instr_q;
    logic [SEL_BITS-1:0] sel_q;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;

    logic                sel_ready;
    logic                sel_rvalid;
    logic [DATA_W-1:0]   sel_rdata;
    logic [SEL_BITS-1:0] new_sel;
    logic                miss;
    logic                timed_out;

    assign ibus_addr_o = addr_q;
    assign dbus_addr_o = addr_q;

    assign new_sel   = cpu_addr_i[ADDR_W-1 -: SEL_BITS];
    assign miss      = !cpu_instr_i && (int'(new_sel) >= N_SLAVES);
    assign timed_out = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT));

    // Handshake inputs of the bus that owns the current transaction.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        if (instr_q) begin
            sel_ready  = ibus_ready_i;
            sel_rvalid = ibus_rvalid_i;
            sel_rdata  = ibus_rdata_i;
        end else begin
            for (int k = 0; k < N_SLAVES; k++) begin
                if (sel_q == SEL_BITS'(k)) begin
                    sel_ready  = dbus_ready_i[k];
                    sel_rvalid = dbus_rvalid_i[k];
                    sel_rdata  = dbus_rdata_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state        <= IDLE;
            instr_q      <= 1'b0;
            sel_q        <= '0;
            cnt          <= '0;
            addr_q       <= '0;
            dbus_wdata_o <= '0;
            dbus_wstrb_o <= '0;
            ibus_valid_o <= 1'b0;
            dbus_valid_o <= '0;
            cpu_ready_o  <= 1'b0;
            err_o        <= 1'b0;
            cpu_rdata_o  <= '0;
        end else if (cke_i) begin
            cpu_ready_o <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_valid_i) begin
                        addr_q       <= cpu_addr_i;
                        dbus_wdata_o <= cpu_wdata_i;
                        dbus_wstrb_o <= cpu_instr_i ? '0 : cpu_wstrb_i;
                        instr_q      <= cpu_instr_i;
                        sel_q        <= new_sel;
                        cnt          <= '0;
                        if (miss) begin
                            state       <= RESP;
                            cpu_ready_o <= 1'b1;
                            err_o       <= 1'b1;
                            cpu_rdata_o <= '0;
                        end else begin
                            state <= REQ;
                            if (cpu_instr_i) ibus_valid_o <= 1'b1;
                            else             dbus_valid_o <= N_SLAVES'(1) << new_sel;
                        end
                    end
                end
                REQ: begin
                    // An accept on the deadline cycle still wins over the timeout.
                    if (sel_ready) begin
                        ibus_valid_o <= 1'b0;
                        dbus_valid_o <= '0;
                        cnt          <= '0;
                        if (dbus_wstrb_o == '0) begin
                            state <= RDATA;
                        end else begin
                            state       <= RESP;
                            cpu_ready_o <= 1'b1;
                            cpu_rdata_o <= '0;
                        end
                    end else if (timed_out) begin
                        ibus_valid_o <= 1'b0;
                        dbus_valid_o <= '0;
                        state        <= RESP;
                        cpu_ready_o  <= 1'b1;
                        err_o        <= 1'b1;
                        cpu_rdata_o  <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RDATA: begin
                    if (sel_rvalid) begin
                        state       <= RESP;
                        cpu_ready_o <= 1'b1;
                        cpu_rdata_o <= sel_rdata;
                    end else if (timed_out) begin
                        state       <= RESP;
                        cpu_ready_o <= 1'b1;
                        err_o       <= 1'b1;
                        cpu_rdata_o <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cpu_bus_bridge.sv
// Bench for iob_cpu_bus_bridge: directed scenarios plus randomized transactions
// checked against a latency/result model derived from the bridge's rules.
module tb_iob_cpu_bus_bridge;

    localparam int T = 4;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          vcyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    logic cke;

    // Instance A: two channels, TIMEOUT=T
    logic        a_cpu_valid, a_cpu_instr;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic [3:0]  a_cpu_wstrb;
    logic        a_cpu_ready, a_err;
    logic        a_ibus_valid, a_ibus_ready, a_ibus_rvalid;
    logic [31:0] a_ibus_addr, a_ibus_rdata;
    logic [1:0]  a_dbus_valid, a_dbus_ready, a_dbus_rvalid;
    logic [31:0] a_dbus_addr, a_dbus_wdata;
    logic [3:0]  a_dbus_wstrb;
    logic [63:0] a_dbus_rdata;

    // Instance B: three channels decoded from two address MSBs, no timeout
    logic        b_cpu_valid, b_cpu_instr;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic [3:0]  b_cpu_wstrb;
    logic        b_cpu_ready, b_err;
    logic        b_ibus_valid, b_ibus_ready, b_ibus_rvalid;
    logic [31:0] b_ibus_addr, b_ibus_rdata;
    logic [2:0]  b_dbus_valid, b_dbus_ready, b_dbus_rvalid;
    logic [31:0] b_dbus_addr, b_dbus_wdata;
    logic [3:0]  b_dbus_wstrb;
    logic [95:0] b_dbus_rdata;

    iob_cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(2), .SEL_BITS(1), .TIMEOUT(T)) dut_a (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cpu_valid_i(a_cpu_valid), .cpu_instr_i(a_cpu_instr), .cpu_addr_i(a_cpu_addr),
        .cpu_wdata_i(a_cpu_wdata), .cpu_wstrb_i(a_cpu_wstrb), .cpu_rdata_o(a_cpu_rdata),
        .cpu_ready_o(a_cpu_ready), .err_o(a_err),
        .ibus_valid_o(a_ibus_valid), .ibus_addr_o(a_ibus_addr), .ibus_ready_i(a_ibus_ready),
        .ibus_rvalid_i(a_ibus_rvalid), .ibus_rdata_i(a_ibus_rdata),
        .dbus_valid_o(a_dbus_valid), .dbus_addr_o(a_dbus_addr), .dbus_wdata_o(a_dbus_wdata),
        .dbus_wstrb_o(a_dbus_wstrb), .dbus_ready_i(a_dbus_ready), .dbus_rvalid_i(a_dbus_rvalid),
        .dbus_rdata_i(a_dbus_rdata)
    );

    iob_cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .SEL_BITS(2), .TIMEOUT(0)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cpu_valid_i(b_cpu_valid), .cpu_instr_i(b_cpu_instr), .cpu_addr_i(b_cpu_addr),
        .cpu_wdata_i(b_cpu_wdata), .cpu_wstrb_i(b_cpu_wstrb), .cpu_rdata_o(b_cpu_rdata),
        .cpu_ready_o(b_cpu_ready), .err_o(b_err),
        .ibus_valid_o(b_ibus_valid), .ibus_addr_o(b_ibus_addr), .ibus_ready_i(b_ibus_ready),
        .ibus_rvalid_i(b_ibus_rvalid), .ibus_rdata_i(b_ibus_rdata),
        .dbus_valid_o(b_dbus_valid), .dbus_addr_o(b_dbus_addr), .dbus_wdata_o(b_dbus_wdata),
        .dbus_wstrb_o(b_dbus_wstrb), .dbus_ready_i(b_dbus_ready), .dbus_rvalid_i(b_dbus_rvalid),
        .dbus_rdata_i(b_dbus_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of one CPU request, from handshake delays alone: rdy = cycles the
    // slave withholds ready, rv = cycles between accept+1 and rvalid, stall = frozen cycles.
    function automatic exp_t model(input logic instr, input logic [3:0] wstrb, input int rdy,
                                   input int rv, input logic [31:0] data, input int stall);
        exp_t r;
        bit   rd;
        rd      = instr || (wstrb == 4'd0);
        r.err   = 1'b0;
        r.rdata = data;
        if (rdy > T) begin
            r.lat = T + 2; r.err = 1'b1; r.rdata = '0; r.vcyc = T + 1;
        end else begin
            r.vcyc = rdy + 1;
            if (!rd)          r.lat = rdy + 2;
            else if (rv > T)  begin r.lat = rdy + T + 3; r.err = 1'b1; r.rdata = '0; end
            else              r.lat = rdy + rv + 3;
        end
        r.lat += stall;
        return r;
    endfunction

    // Acts as CPU and slaves on instance A for one transaction and checks the outcome.
    task automatic run_a(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int rdy, input int rv,
                         input logic [31:0] data, input int stall_at, input string tag);
        exp_t        ex;
        int          sel, e, vcnt, acc, stall_left, lat;
        logic [1:0]  onehot;
        logic [31:0] got_rdata;
        logic        got_err;
        bit          rd, done, was_en, vis, fields_ok;
        ex  = model(instr, wstrb, rdy, rv, data, (stall_at >= 0) ? 3 : 0);
        sel = int'(addr[31]);
        onehot = 2'b01 << sel;
        rd  = instr || (wstrb == 4'd0);
        a_cpu_valid = 1'b1; a_cpu_instr = instr; a_cpu_addr = addr;
        a_cpu_wdata = wdata; a_cpu_wstrb = wstrb;
        cke = 1'b1;
        e = 0; vcnt = 0; acc = -1; stall_left = 3; lat = -1;
        done = 1'b0; fields_ok = 1'b1; got_rdata = '0; got_err = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk); #1;
            was_en = cke;
            if (was_en) e++;
            if (instr) fields_ok &= (a_dbus_valid == 2'b00);
            else       fields_ok &= !a_ibus_valid;
            vis = instr ? a_ibus_valid : (a_dbus_valid != 2'b00);
            if (vis) begin
                if (instr) fields_ok &= (a_ibus_addr == addr) && (a_dbus_wstrb == 4'd0);
                else fields_ok &= (a_dbus_valid == onehot) && (a_dbus_addr == addr) &&
                                  (a_dbus_wdata == wdata) && (a_dbus_wstrb == wstrb);
            end
            if (a_cpu_ready) begin
                done = 1'b1; lat = n + 1; got_rdata = a_cpu_rdata; got_err = a_err;
                a_ibus_ready = 1'b0; a_ibus_rvalid = 1'b0;
                a_dbus_ready = 2'b00; a_dbus_rvalid = 2'b00;
            end else if (was_en) begin
                // Unselected handshake lines carry noise; the selected ones follow the schedule.
                a_ibus_ready = 1'b0; a_ibus_rvalid = 1'b0; a_ibus_rdata = $urandom;
                a_dbus_ready = 2'($urandom); a_dbus_rvalid = 2'($urandom);
                a_dbus_rdata = {$urandom, $urandom};
                if (!instr) begin
                    a_ibus_ready = 1'($urandom); a_ibus_rvalid = 1'($urandom);
                    a_dbus_ready[sel] = 1'b0; a_dbus_rvalid[sel] = 1'b0;
                end
                if (vis) begin
                    vcnt++;
                    if (vcnt - 1 == rdy) begin
                        acc = e;
                        if (instr) begin a_ibus_ready = 1'b1; a_ibus_rvalid = 1'b1; end
                        else begin a_dbus_ready[sel] = 1'b1; a_dbus_rvalid[sel] = 1'b1; end
                    end
                end
                if (rd && acc >= 0 && e == acc + 1 + rv) begin
                    if (instr) begin a_ibus_rvalid = 1'b1; a_ibus_rdata = data; end
                    else begin a_dbus_rvalid[sel] = 1'b1; a_dbus_rdata[sel*32 +: 32] = data; end
                end
            end
            if (!done && stall_at >= 0 && e == stall_at && stall_left > 0) begin
                cke = 1'b0; stall_left--;
            end else begin
                cke = 1'b1;
            end
        end
        cke = 1'b1;
        check({tag, " completes"}, done, 1'b1);
        check({tag, " latency"}, lat, ex.lat);
        check({tag, " err"}, got_err, ex.err);
        if (rd || ex.err) check({tag, " rdata"}, got_rdata, ex.rdata);
        check({tag, " valid cycles"}, vcnt, ex.vcyc);
        check({tag, " request fields"}, fields_ok, 1'b1);
        // CPU keeps valid through the response cycle; nothing may be re-issued.
        @(posedge clk); #1;
        check({tag, " single pulse"}, {a_cpu_ready, a_ibus_valid, a_dbus_valid}, 4'b0);
        a_cpu_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        any_valid;
        logic        r_instr;
        logic [31:0] r_addr, r_wdata, r_data;
        logic [3:0]  r_wstrb;
        int          r_rdy, r_rv, r_stall;

        arst_n = 1'b0; cke = 1'b1;
        a_cpu_valid = 1'b1; a_cpu_instr = 1'b0; a_cpu_addr = 32'h8000_0000;
        a_cpu_wdata = 32'h1111_2222; a_cpu_wstrb = 4'hF;
        a_ibus_ready = 1'b1; a_ibus_rvalid = 1'b1; a_ibus_rdata = 32'hDEAD_BEEF;
        a_dbus_ready = 2'b11; a_dbus_rvalid = 2'b11; a_dbus_rdata = '1;
        b_cpu_valid = 1'b0; b_cpu_instr = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0; b_cpu_wstrb = '0;
        b_ibus_ready = 1'b0; b_ibus_rvalid = 1'b0; b_ibus_rdata = '0;
        b_dbus_ready = '0; b_dbus_rvalid = '0; b_dbus_rdata = '0;

        // Reset held with activity on the inputs: every output stays zero.
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs A", {a_cpu_rdata, a_cpu_ready, a_err, a_ibus_valid, a_ibus_addr,
              a_dbus_valid, a_dbus_addr, a_dbus_wdata, a_dbus_wstrb}, '0);
        check("reset outputs B", {b_cpu_rdata, b_cpu_ready, b_err, b_ibus_valid, b_ibus_addr,
              b_dbus_valid, b_dbus_addr, b_dbus_wdata, b_dbus_wstrb}, '0);
        a_cpu_valid = 1'b0;
        a_ibus_ready = 1'b0; a_ibus_rvalid = 1'b0;
        a_dbus_ready = 2'b00; a_dbus_rvalid = 2'b00;
        arst_n = 1'b1;

        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            any_valid |= a_ibus_valid | (|a_dbus_valid) | a_cpu_ready | b_cpu_ready | (|b_dbus_valid);
        end
        check("idle no valid", any_valid, 1'b0);

        run_a(1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'h0010_0513, -1, "fetch");
        run_a(1'b0, 32'h8000_0010, 32'hCAFE_BABE, 4'hF, 3, 0, 32'h0, -1, "write ch1");
        run_a(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, 2, 32'h1357_9BDF, -1, "read ch0");

        // Instance B: decode miss on sel=3, then a read of channel 2.
        b_cpu_valid = 1'b1; b_cpu_addr = 32'hC000_0000; b_cpu_wstrb = 4'h0;
        @(posedge clk); #1;
        check("miss ready+err", {b_cpu_ready, b_err}, 2'b11);
        check("miss rdata", b_cpu_rdata, 32'h0);
        check("miss no valid", {b_ibus_valid, b_dbus_valid}, 4'b0);
        @(posedge clk); #1;
        check("miss pulse ends", {b_cpu_ready, b_err, b_dbus_valid}, 5'b0);
        b_cpu_valid = 1'b0;
        @(posedge clk); #1;
        b_cpu_valid = 1'b1; b_cpu_addr = 32'h8000_0004;
        @(posedge clk); #1;
        check("B ch2 valid", b_dbus_valid, 3'b100);
        b_cpu_valid = 1'b1; b_dbus_ready = 3'b100;
        @(posedge clk); #1;
        b_dbus_ready = 3'b000; b_dbus_rvalid = 3'b100; b_dbus_rdata[95:64] = 32'h1234_5678;
        @(posedge clk); #1;
        b_dbus_rvalid = 3'b000;
        check("B ch2 ready", {b_cpu_ready, b_err}, 2'b10);
        check("B ch2 rdata", b_cpu_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        b_cpu_valid = 1'b0;

        // Timeout in both phases, with the accept/timeout boundary on each side.
        run_a(1'b0, 32'h0000_0040, 32'h0, 4'h0, 99, 0, 32'hAAAA_0001, -1, "timeout req");
        a_dbus_rvalid = 2'b01; a_dbus_rdata = {32'h0, 32'hBAD0_BAD0};
        repeat (2) begin
            @(posedge clk); #1;
            check("late rvalid ignored", {a_cpu_ready, a_err}, 2'b00);
        end
        a_dbus_rvalid = 2'b00;
        run_a(1'b0, 32'h0000_0048, 32'h0, 4'h0, 1, 2, 32'h5555_AAAA, -1, "after timeout");
        run_a(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 99, 32'hAAAA_0002, -1, "timeout rdata");
        run_a(1'b0, 32'h8000_0050, 32'h0F0F_0F0F, 4'h3, T, 0, 32'h0, -1, "ready at limit");
        run_a(1'b0, 32'h8000_0054, 32'h0F0F_0F0F, 4'h3, T + 1, 0, 32'h0, -1, "ready past limit");
        run_a(1'b1, 32'h0000_0058, 32'h0, 4'h0, 0, T, 32'h7777_0000, -1, "rvalid at limit");

        // Asynchronous reset while waiting in RDATA.
        a_cpu_valid = 1'b1; a_cpu_instr = 1'b0; a_cpu_addr = 32'h0000_0200;
        a_cpu_wdata = 32'h0; a_cpu_wstrb = 4'h0;
        @(posedge clk); #1;
        a_dbus_ready = 2'b01;
        @(posedge clk); #1;
        a_dbus_ready = 2'b00;
        #2 arst_n = 1'b0;
        #1;
        check("async reset mid-read", {a_cpu_rdata, a_cpu_ready, a_err, a_ibus_valid, a_ibus_addr,
              a_dbus_valid, a_dbus_addr, a_dbus_wdata, a_dbus_wstrb}, '0);
        a_cpu_valid = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        run_a(1'b0, 32'h8000_0020, 32'h0, 4'h0, 2, 1, 32'h600D_F00D, 2, "cke stall");

        for (int i = 0; i < 40; i++) begin
            r_instr = 1'($urandom);
            r_addr  = $urandom & 32'hFFFF_FFFC;
            r_wdata = $urandom;
            r_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            r_data  = $urandom;
            r_rdy   = $urandom_range(0, T + 2);
            r_rv    = $urandom_range(0, T + 1);
            r_stall = ($urandom_range(0, 3) == 0) ? 1 : -1;
            run_a(r_instr, r_addr, r_wdata, r_wstrb, r_rdy, r_rv, r_data, r_stall, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_cpu_bus_bridge.md
# iob_cpu_bus_bridge

Registered bridge between a CPU native memory port (valid/ready, instruction flag, held request) and one IOb instruction bus plus N_SLAVES address-decoded IOb data buses. It sits between the core and the interconnect, replaces combinational bus splitting with a one-outstanding-transaction state machine, and adds:
- data-side address decoding;
- a response timeout with an error flag;
- a decode-miss error.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 strobe bits.
- N_SLAVES, 2, number of data channels (1..2**SEL_BITS).
- SEL_BITS, 1, address MSBs used for channel decode.
- TIMEOUT, 255, max wait cycles per phase; 0 disables timeout.

Ports (reset is asynchronous and active-low; one clock):
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; when low, all registers hold.
- cpu_valid_i  in  1  CPU request, held until cpu_ready_o.
- cpu_instr_i  in  1  instruction fetch.
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_wdata_i  in  DATA_W  write data.
- cpu_wstrb_i  in  DATA_W/8  write strobes; 0 = read.
- cpu_rdata_o  out  DATA_W  read data, valid with cpu_ready_o.
- cpu_ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  error pulse, coincident with cpu_ready_o.
- ibus_valid_o  out  1  instruction request.
- ibus_addr_o  out  ADDR_W  instruction address.
- ibus_ready_i  in  1  instruction request accepted.
- ibus_rvalid_i  in  1  instruction read data valid.
- ibus_rdata_i  in  DATA_W  instruction data.
- dbus_valid_o  out  N_SLAVES  per-channel data request, one-hot or zero.
- dbus_addr_o  out  ADDR_W  shared data address.
- dbus_wdata_o  out  DATA_W  shared write data.
- dbus_wstrb_o  out  DATA_W/8  shared strobes.
- dbus_ready_i  in  N_SLAVES  per-channel accept.
- dbus_rvalid_i  in  N_SLAVES  per-channel read valid.
- dbus_rdata_i  in  N_SLAVES*DATA_W  channel k at bits [k*DATA_W +: DATA_W].

## Operation
- FSM states: IDLE, REQ, RDATA, RESP. All outputs are registered.
- IDLE, on cpu_valid_i:
  - Latch addr, wdata and wstrb; force wstrb to 0 if cpu_instr_i.
  - Select the target:
    - cpu_instr_i → ibus.
    - Otherwise → channel sel = cpu_addr_i[ADDR_W-1 -: SEL_BITS].
  - If sel ≥ N_SLAVES: go to RESP with err=1 and rdata=0; no bus request is issued.
  - Else: assert the selected valid and go to REQ.
- REQ: hold valid, address, wdata and wstrb stable until the selected ready is 1 at a clock edge. On that edge, drop valid:
  - read → RDATA;
  - write → RESP.
- RDATA: wait for the selected rvalid; capture its rdata → RESP.
  - rvalid from non-selected channels is ignored.
  - rvalid seen in any other state is ignored.
- RESP: cpu_ready_o=1 for exactly one cycle, then → IDLE.
  - The CPU still holds valid during RESP; IDLE is only re-entered afterwards, so no double issue.
- Timeout (TIMEOUT>0):
  - A counter clears on entry to REQ and to RDATA, and increments each enabled cycle in those states.
  - When the count equals TIMEOUT: drop valid and go to RESP with err=1 and rdata=0.
  - A late rvalid from the abandoned slave is ignored.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- Reset mid-transaction:
  - All state clears immediately and any bus handshake in progress is abandoned.
  - After release the FSM is in IDLE.

## Timing
- Reset values: all valid outputs 0; cpu_ready_o 0; err_o 0; cpu_rdata_o 0; address, wdata and wstrb outputs 0; state IDLE.
- Cycle 0 is the first edge with cpu_valid_i=1 in IDLE.
- Read latency: with ready=1 in the first cycle of valid and rvalid one cycle later, cpu_ready_o is high in cycle 3. Each extra ready or rvalid wait cycle adds one.
- Write latency: cpu_ready_o in cycle 2 minimum.
- Decode miss: cpu_ready_o in cycle 1.
- Timeout: cpu_ready_o TIMEOUT+2 cycles after REQ or RDATA entry.
- Ready and rvalid in the same cycle while in REQ: the rvalid is ignored. Slaves must give rvalid at least one cycle after acceptance.
- cke_i=0: the FSM, counter and outputs freeze. Input handshakes are sampled only when cke_i=1.

## Test plan
- Reset: hold arst_n_i=0 → all outputs 0. Release, cpu_valid_i=0 for 10 cycles → no valid asserted.
- Fetch, addr 0x0000_0100, ibus ready immediate, rvalid +1 with 0x0010_0513 → ibus_valid_o for 1 cycle; cpu_ready_o in cycle 3 with rdata 0x0010_0513; dbus_valid_o stays 0.
- Write to 0x8000_0010, wdata 0xCAFEBABE, wstrb 0xF; channel 1 ready delayed 3 cycles → dbus_valid_o=2'b10 for 4 cycles with stable fields; cpu_ready_o in cycle 5; no wait for rvalid.
- N_SLAVES=3, SEL_BITS=2, read of 0xC000_0000 → no valid asserted; cpu_ready_o and err_o in cycle 1; rdata 0.
- TIMEOUT=4, read of channel 0 never answered → valid dropped, err_o with cpu_ready_o. A later injected rvalid is ignored and the next read completes normally.
- Assert arst_n_i=0 while in RDATA → outputs clear asynchronously. After release, a fresh read completes with the correct data; cke_i=0 for 3 cycles mid-REQ stretches latency by exactly 3.
